// File: rtl/covervector_player.sv
// covervector_player
// Cover-vector sequencer: a load port fills an on-chip vector memory, and a
// start command plays the stored vectors out in order over valid/ready
// handshakes. Vectors go round-robin across NUM_CH consumer channels. The
// block supports a vector count, loop mode, early stop, and pass/vector
// counters.
module covervector_player #(
    parameter int VEC_W  = 512,
    parameter int DEPTH  = 10001,
    parameter int NUM_CH = 2,
    parameter int AW     = $clog2(DEPTH),
    parameter int CW     = $clog2(DEPTH + 1),
    parameter int PW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_we,
    input  logic [AW-1:0]     load_addr,
    input  logic [VEC_W-1:0]  load_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [CW-1:0]     num_vectors,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [VEC_W-1:0]  out_data,
    output logic [AW-1:0]     out_index,
    output logic              busy,
    output logic              done,
    output logic [31:0]       vec_count,
    output logic [PW-1:0]     pass_count
);

    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Playback context
    logic [AW-1:0]    idx_reg;
    logic [CHW-1:0]   ch_reg;
    logic [CW-1:0]    n_reg;
    logic             loop_reg;
    logic             stop_pending_reg;
    logic [31:0]      vec_count_reg;
    logic [PW-1:0]    pass_count_reg;

    // Vector memory and its registered read port
    logic [VEC_W-1:0] mem [DEPTH];
    logic [VEC_W-1:0] rd_data_reg;

    // Decoded control
    logic             idle_or_done;
    logic             present;
    logic [CW-1:0]    n_clamped;
    logic             start_go;
    logic             hs;
    logic             at_last;
    logic             stop_now;
    logic             wr_en;

    assign idle_or_done = (state_reg == S_IDLE) || (state_reg == S_DONE);
    assign n_clamped    = (num_vectors > CW'(DEPTH)) ? CW'(DEPTH) : num_vectors;
    assign start_go     = idle_or_done && start && (n_clamped != '0);
    assign hs           = |(out_valid & out_ready);
    assign at_last      = (CW'(idx_reg) == (n_reg - CW'(1)));
    assign stop_now     = stop_pending_reg || stop;
    // Loads are only taken while the read port is idle, so the single port
    // never sees a write and a read in the same cycle.
    assign wr_en        = load_we && idle_or_done && (32'(load_addr) < 32'(DEPTH));

    // Memory write and synchronous read; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[load_addr] <= load_data;
        end
        if (state_reg == S_FETCH) begin
            rd_data_reg <= mem[idx_reg];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = (n_clamped == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (hs) begin
                    if (stop_now) begin
                        state_next = S_DONE;
                    end else if (at_last && !loop_reg) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        present   = 1'b0;
        out_data  = '0;
        out_index = '0;
        case (state_reg)
            S_FETCH: begin
                busy = 1'b1;
            end
            S_PRESENT: begin
                busy      = 1'b1;
                present   = 1'b1;
                out_data  = rd_data_reg;
                out_index = idx_reg;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // One-hot channel valid for the channel currently holding the turn
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_valid
            assign out_valid[gi] = present && (ch_reg == CHW'(gi));
        end
    endgenerate

    // Playback context: index, channel pointer, counters and stop request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg          <= '0;
            ch_reg           <= '0;
            n_reg            <= '0;
            loop_reg         <= 1'b0;
            stop_pending_reg <= 1'b0;
            vec_count_reg    <= '0;
            pass_count_reg   <= '0;
        end else if (start_go) begin
            idx_reg          <= '0;
            ch_reg           <= '0;
            n_reg            <= n_clamped;
            loop_reg         <= loop_en;
            stop_pending_reg <= 1'b0;
            vec_count_reg    <= '0;
            pass_count_reg   <= '0;
        end else begin
            if (busy && stop) begin
                stop_pending_reg <= 1'b1;
            end
            if (hs) begin
                vec_count_reg <= vec_count_reg + 32'd1;
                // The channel pointer keeps rotating across loop wraps
                ch_reg <= (ch_reg == CHW'(NUM_CH - 1)) ? '0 : ch_reg + CHW'(1);
                if (!stop_now) begin
                    if (at_last) begin
                        idx_reg <= '0;
                        if (pass_count_reg != '1) begin
                            pass_count_reg <= pass_count_reg + PW'(1);
                        end
                    end else begin
                        idx_reg <= idx_reg + AW'(1);
                    end
                end
            end
        end
    end

    assign vec_count  = vec_count_reg;
    assign pass_count = pass_count_reg;

endmodule

// File: tb/tb_covervector_player.sv
// Bench for covervector_player: directed scenarios plus randomized playback
// runs, all checked against a behavioural model of the playback order.
module tb_covervector_player;

    localparam int VEC_W  = 32;
    localparam int DEPTH  = 16;
    localparam int NUM_CH = 2;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int PW     = 16;

    logic              clk;
    logic              rst_n;
    logic              load_we;
    logic [AW-1:0]     load_addr;
    logic [VEC_W-1:0]  load_data;
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [CW-1:0]     num_vectors;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;
    logic [VEC_W-1:0]  out_data;
    logic [AW-1:0]     out_index;
    logic              busy;
    logic              done;
    logic [31:0]       vec_count;
    logic [PW-1:0]     pass_count;

    covervector_player #(
        .VEC_W(VEC_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH),
        .AW(AW), .CW(CW), .PW(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .start(start), .stop(stop), .loop_en(loop_en), .num_vectors(num_vectors),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index),
        .busy(busy), .done(done), .vec_count(vec_count), .pass_count(pass_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [VEC_W-1:0] mem_model [DEPTH];
    bit               mon_on = 1'b0;
    int               n_eff;
    bit               lp_exp;
    int               hs_cnt;
    int               pass_exp;
    int               stall_cnt;
    bit               stop_armed;
    bit               term;
    bit               fetch_flag;
    int               log_n;
    logic [VEC_W-1:0] log_data [64];
    int               log_idx  [64];
    int               log_ch   [64];

    int exp_idx3 [5] = '{0, 1, 2, 0, 1};
    int exp_ch3  [5] = '{0, 1, 0, 1, 0};

    // Compare process: the k-th handshake of a run must carry vector k mod N
    // on channel k mod NUM_CH, one fetch cycle separates presentations, and
    // the run ends after the last vector (no loop) or after the first
    // handshake at or after a stop request.
    always @(negedge clk) begin
        int e_idx;
        int e_ch;
        bit stopping;
        if (mon_on) begin
            if (term) begin
                check("done_after_end", done, 1);
                check("busy_after_end", busy, 0);
                check("valid_after_end", out_valid, 0);
            end else begin
                check("done_while_running", done, 0);
                check("busy_while_running", busy, 1);
                check("vec_count_running", vec_count, hs_cnt);
                check("pass_count_running", pass_count, pass_exp);
                if (fetch_flag) begin
                    check("valid_in_fetch", out_valid, 0);
                    fetch_flag = 1'b0;
                end else begin
                    e_idx = hs_cnt % n_eff;
                    e_ch  = hs_cnt % NUM_CH;
                    check("valid_onehot", out_valid, 64'(1) << e_ch);
                    check("out_index", out_index, e_idx);
                    check("out_data", out_data, mem_model[e_idx]);
                    if ((out_valid & out_ready) != '0) begin
                        if (log_n < 64) begin
                            log_data[log_n] = out_data;
                            log_idx[log_n]  = int'(out_index);
                            log_ch[log_n]   = e_ch;
                            log_n++;
                        end
                        stopping   = stop_armed || stop;
                        hs_cnt++;
                        fetch_flag = 1'b1;
                        if (stopping) begin
                            term = 1'b1;
                        end else if (e_idx == n_eff - 1) begin
                            pass_exp++;
                            if (!lp_exp) term = 1'b1;
                        end
                    end else begin
                        stall_cnt++;
                    end
                end
                if (stop) stop_armed = 1'b1;
            end
        end
    end

    function automatic logic [NUM_CH-1:0] rdy(input int mode, input int cyc);
        case (mode)
            0:       return '1;
            1:       return NUM_CH'($urandom);
            default: return (cyc >= 4 && cyc <= 8) ? NUM_CH'(1) : '1;
        endcase
    endfunction

    task automatic load(input int a, input logic [VEC_W-1:0] d);
        load_we   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        @(posedge clk); #1;
        load_we   = 1'b0;
        mem_model[a] = d;
    endtask

    // Start a run, drive readies/stop/write noise each cycle, wait for done
    task automatic run_play(input int n, input bit lp, input int rmode, input int stop_cyc,
                            input int noise, output int cyc_done);
        int cyc;
        num_vectors = CW'(n);
        loop_en     = lp;
        out_ready   = rdy(rmode, 0);
        start       = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        cyc        = 1;
        n_eff      = (n > DEPTH) ? DEPTH : n;
        lp_exp     = lp;
        hs_cnt     = 0;
        pass_exp   = 0;
        stall_cnt  = 0;
        stop_armed = 1'b0;
        term       = 1'b0;
        fetch_flag = 1'b1;
        log_n      = 0;
        mon_on     = 1'b1;
        while (!done && cyc < 3000) begin
            out_ready = rdy(rmode, cyc);
            stop      = (cyc == stop_cyc);
            if (noise != 0 && busy) begin
                load_we   = 1'b1;
                load_addr = (noise == 1) ? AW'(1) : AW'($urandom_range(0, DEPTH - 1));
                load_data = (noise == 1) ? VEC_W'('hFF) : VEC_W'($urandom);
            end else begin
                load_we = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        stop     = 1'b0;
        load_we  = 1'b0;
        cyc_done = cyc;
        @(negedge clk); #1;
        mon_on = 1'b0;
        check("end_done", done, 1);
        check("end_model_terminated", term, 1);
        check("end_vec_count", vec_count, hs_cnt);
        check("end_pass_count", pass_count, pass_exp);
        $display("run n=%0d loop=%0d mode=%0d stop_cyc=%0d: handshakes=%0d passes=%0d cycles=%0d",
                 n, lp, rmode, stop_cyc, hs_cnt, pass_exp, cyc_done);
    endtask

    initial begin
        int cyc;
        bit seen_valid;
        rst_n       = 1'b0;
        load_we     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        start       = 1'b0;
        stop        = 1'b0;
        loop_en     = 1'b0;
        num_vectors = '0;
        out_ready   = '0;

        // Reset values
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vec_count", vec_count, 0);
        check("rst_pass_count", pass_count, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) begin
            load(i, (i < 4) ? VEC_W'('hA0 + i) : VEC_W'($urandom));
        end

        // Free-flowing playback of four vectors
        run_play(4, 1'b0, 0, -1, 0, cyc);
        check("t1_done_cycle", cyc, 9);
        check("t1_vec_count", vec_count, 4);
        check("t1_pass_count", pass_count, 1);
        for (int i = 0; i < 4; i++) begin
            check("t1_data", log_data[i], 'hA0 + i);
            check("t1_channel", log_ch[i], i % 2);
        end

        // Back-pressure on channel 1 while A1 is presented
        run_play(4, 1'b0, 2, -1, 0, cyc);
        check("t2_stall_cycles", stall_cnt, 5);
        check("t2_data1", log_data[1], 'hA1);
        check("t2_vec_count", vec_count, 4);

        // Loop mode with a stop pulse at the fifth handshake
        run_play(3, 1'b1, 0, 10, 0, cyc);
        check("t3_vec_count", vec_count, 5);
        check("t3_pass_count", pass_count, 1);
        for (int i = 0; i < 5; i++) begin
            check("t3_index", log_idx[i], exp_idx3[i]);
            check("t3_channel", log_ch[i], exp_ch3[i]);
        end

        // Asynchronous reset while index 2 is presented
        num_vectors = CW'(4);
        loop_en     = 1'b0;
        out_ready   = '1;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid != '0 && out_index == AW'(2)) break;
        end
        out_ready = '0;
        check("t5_pre_valid", out_valid, 1);
        check("t5_pre_index", out_index, 2);
        check("t5_pre_vec_count", vec_count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_vec_count", vec_count, 0);
        check("t5_rst_pass_count", pass_count, 0);
        check("t5_rst_data", out_data, 0);
        @(posedge clk); #2;
        rst_n     = 1'b1;
        out_ready = '1;
        @(posedge clk); #1;

        // Zero-length start goes straight to done
        num_vectors = '0;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_done", done, 1);
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t4_busy", busy, 0);
            if (out_valid != '0) seen_valid = 1'b1;
            @(posedge clk); #1;
        end
        check("t4_never_valid", seen_valid, 0);

        // Fresh start after reset replays from index 0 with memory intact
        run_play(4, 1'b0, 0, -1, 0, cyc);
        check("t5_replay_data0", log_data[0], 'hA0);
        check("t5_replay_index0", log_idx[0], 0);
        check("t5_replay_data2", log_data[2], 'hA2);

        // Writes during playback are ignored
        run_play(4, 1'b0, 1, -1, 1, cyc);
        check("t6_data1_kept", log_data[1], 'hA1);
        run_play(2, 1'b0, 0, -1, 0, cyc);
        check("t6_data1_after", log_data[1], 'hA1);

        // Vector count above DEPTH is clamped
        run_play(DEPTH + 5, 1'b0, 1, -1, 0, cyc);
        check("t6_clamp_vec_count", vec_count, DEPTH);
        check("t6_clamp_last_index", log_idx[DEPTH - 1], DEPTH - 1);

        // Randomized runs
        for (int r = 0; r < 20; r++) begin
            int n;
            bit lp;
            int sc;
            for (int k = 0; k < 2; k++) begin
                load($urandom_range(0, DEPTH - 1), VEC_W'($urandom));
            end
            n  = $urandom_range(1, DEPTH + 3);
            lp = 1'($urandom_range(0, 1));
            if (lp || $urandom_range(0, 1) == 1) sc = $urandom_range(2, 80);
            else sc = -1;
            run_play(n, lp, 1, sc, 2, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
